// File: rtl/uart_tx_arbiter.sv
// Message-atomic round-robin arbiter sharing one UART TX FIFO among NUM_REQ byte streams.
// Define UART_ARB_TIMEOUT_EN to build the watchdog that revokes a grant idle for TIMEOUT_CYCLES.

module uart_tx_arbiter #(
   parameter int NUM_REQ        = 4,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NUM_REQ-1:0]   req_valid,
   input  logic [8*NUM_REQ-1:0] req_data,
   input  logic [NUM_REQ-1:0]   req_last,
   output logic [NUM_REQ-1:0]   req_ready,
   output logic [NUM_REQ-1:0]   grant,
   input  logic                 fifo_ready,
   output logic                 start_uart,
   output logic [7:0]           uart_tx_data,
   output logic                 busy,
   output logic                 timeout
);

   localparam int PW = $clog2(NUM_REQ);

   typedef enum logic [1:0] {IDLE, SEND, HOLD} state_t;

   state_t        state;
   logic [PW-1:0] rr_ptr;
   logic [PW-1:0] grant_idx;
   logic [PW-1:0] next_idx;
   logic [PW-1:0] cand;
   logic          last_flag;
   logic          hold_cnt;
   logic          xfer;
   logic [7:0]    sel_data;
   logic          sel_last;

`ifdef UART_ARB_TIMEOUT_EN
   logic [15:0]   idle_cnt;
`endif

   // Scan from the farthest candidate back toward rr_ptr+1 so the nearest valid requester wins.
   always_comb begin
      next_idx = '0;
      cand     = '0;
      for (int k = NUM_REQ; k >= 1; k--) begin
         cand = PW'((int'(rr_ptr) + k) % NUM_REQ);
         if (req_valid[cand])
            next_idx = cand;
      end
   end

   assign req_ready = (state == SEND && fifo_ready) ? grant : '0;
   assign xfer      = |(req_valid & req_ready);
   assign sel_data  = req_data[int'(grant_idx) * 8 +: 8];
   assign sel_last  = req_last[grant_idx];
   assign busy      = (state != IDLE);

   // Two HOLD cycles after every push give the lagging fifo_ready time to reflect the new count.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         grant        <= '0;
         grant_idx    <= '0;
         rr_ptr       <= PW'(NUM_REQ - 1);
         start_uart   <= 1'b0;
         uart_tx_data <= 8'h00;
         last_flag    <= 1'b0;
         hold_cnt     <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
         idle_cnt     <= '0;
         timeout      <= 1'b0;
`endif
      end else begin
         start_uart <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
         timeout    <= 1'b0;
`endif
         case (state)
            IDLE: begin
               if (|req_valid) begin
                  grant     <= NUM_REQ'(1) << next_idx;
                  grant_idx <= next_idx;
                  state     <= SEND;
               end
            end
            SEND: begin
               if (xfer) begin
                  start_uart   <= 1'b1;
                  uart_tx_data <= sel_data;
                  last_flag    <= sel_last;
                  hold_cnt     <= 1'b0;
                  state        <= HOLD;
`ifdef UART_ARB_TIMEOUT_EN
                  idle_cnt     <= '0;
`endif
               end
`ifdef UART_ARB_TIMEOUT_EN
               else if (idle_cnt == 16'(TIMEOUT_CYCLES - 1)) begin
                  state    <= IDLE;
                  rr_ptr   <= grant_idx;
                  grant    <= '0;
                  timeout  <= 1'b1;
                  idle_cnt <= '0;
               end else begin
                  idle_cnt <= idle_cnt + 16'd1;
               end
`endif
            end
            HOLD: begin
               if (!hold_cnt) begin
                  hold_cnt <= 1'b1;
               end else begin
                  hold_cnt <= 1'b0;
                  if (last_flag) begin
                     state  <= IDLE;
                     rr_ptr <= grant_idx;
                     grant  <= '0;
                  end else begin
                     state  <= SEND;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifndef UART_ARB_TIMEOUT_EN
   // Without the watchdog a granted requester keeps the UART until its last byte.
   assign timeout = 1'b0 & (TIMEOUT_CYCLES != 0);
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: arbitration table, directed corner sequences,
// and randomized traffic compared against a message-level round-robin reference model.

module tb_uart_tx_arbiter;

   localparam int N  = 4;
   localparam int TO = 16;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic [N-1:0]   req_valid = '0;
   logic [8*N-1:0] req_data = '0;
   logic [N-1:0]   req_last = '0;
   logic [N-1:0]   req_ready;
   logic [N-1:0]   grant;
   logic           fifo_ready = 1'b0;
   logic           start_uart;
   logic [7:0]     uart_tx_data;
   logic           busy;
   logic           timeout;

   uart_tx_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_data     (req_data),
      .req_last     (req_last),
      .req_ready    (req_ready),
      .grant        (grant),
      .fifo_ready   (fifo_ready),
      .start_uart   (start_uart),
      .uart_tx_data (uart_tx_data),
      .busy         (busy),
      .timeout      (timeout)
   );

   always #5 clk = ~clk;

   typedef struct { logic [N-1:0] valid; int exp_idx; } vec_t;
   typedef struct { int owner; logic [7:0] data; } exp_t;

   int         total = 0;
   int         bad = 0;
   vec_t       vecs[12];
   exp_t       exp_q[$];
   logic [8:0] src_q[N][$];
   logic [8:0] model_q[N][$];
   logic [7:0] msg[3];
   logic [N-1:0] hs;
   int         b, nstrobe, last_c;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic [N-1:0] valid, input logic [8*N-1:0] data,
                                input logic [N-1:0] last, input logic fr);
      req_valid  = valid;
      req_data   = data;
      req_last   = last;
      fifo_ready = fr;
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
      end
   endtask

   task automatic doReset();
      rst = 1'b1;
      applyStimulus('0, '0, '0, 1'b1);
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic checkResetValues(input string tag);
      checkOutput({tag, "_grant"},   32'(grant), 0);
      checkOutput({tag, "_ready"},   32'(req_ready), 0);
      checkOutput({tag, "_start"},   32'(start_uart), 0);
      checkOutput({tag, "_data"},    32'(uart_tx_data), 0);
      checkOutput({tag, "_busy"},    32'(busy), 0);
      checkOutput({tag, "_timeout"}, 32'(timeout), 0);
   endtask

   function automatic logic [8*N-1:0] tagData(input logic [3:0] tag);
      logic [8*N-1:0] d;
      d = '0;
      for (int i = 0; i < N; i++)
         d[8*i +: 8] = {4'(i), tag};
      return d;
   endfunction

   // Builds message queues, derives the expected byte stream by rotating over whole
   // messages, then drives the requesters and compares every strobe with that stream.
   task automatic runScenario(input bit randomized, input string tag);
      int nmsg, len, ptr, owner, strobes, cyc, total_bytes;
      logic [8:0]     ent;
      logic [N-1:0]   mid, vld, lst, mask, shs;
      logic [8*N-1:0] dat;
      logic           fr;
      exp_t           e;
      exp_q.delete();
      total_bytes = 0;
      for (int i = 0; i < N; i++) begin
         src_q[i].delete();
         model_q[i].delete();
         nmsg = randomized ? int'($urandom_range(1, 3)) : 2;
         for (int m = 0; m < nmsg; m++) begin
            len = randomized ? int'($urandom_range(1, 3)) : 1;
            for (int k = 0; k < len; k++) begin
               ent = {(k == len - 1), 8'($urandom_range(0, 255))};
               src_q[i].push_back(ent);
               model_q[i].push_back(ent);
               total_bytes++;
            end
         end
      end
      ptr = N - 1;
      owner = 0;
      while (exp_q.size() < total_bytes) begin
         for (int k = 1; k <= N; k++) begin
            owner = (ptr + k) % N;
            if (model_q[owner].size() > 0) break;
         end
         do begin
            ent = model_q[owner].pop_front();
            e.owner = owner;
            e.data  = ent[7:0];
            exp_q.push_back(e);
         end while (!ent[8]);
         ptr = owner;
      end
      mid = '0;
      strobes = 0;
      cyc = 0;
      while (exp_q.size() > 0 && cyc < 3000) begin
         dat = '0;
         for (int i = 0; i < N; i++) begin
            vld[i] = (src_q[i].size() > 0) && (!mid[i] || !randomized || $urandom_range(0, 4) != 0);
            lst[i] = (src_q[i].size() > 0) ? src_q[i][0][8] : 1'b0;
            if (src_q[i].size() > 0) dat[8*i +: 8] = src_q[i][0][7:0];
         end
         fr = randomized ? ($urandom_range(0, 3) != 0) : 1'b1;
         applyStimulus(vld, dat, lst, fr);
         mask = fr ? N'(1 << exp_q[0].owner) : '0;
         checkOutput({tag, "_ready_owner"}, 32'(req_ready & ~mask), 0);
         shs = req_valid & req_ready;
         tick();
         checkOutput({tag, "_strobe"}, 32'(start_uart), 32'(shs != 0));
         checkOutput({tag, "_timeout"}, 32'(timeout), 0);
         for (int i = 0; i < N; i++) begin
            if (shs[i]) begin
               ent = src_q[i].pop_front();
               mid[i] = !ent[8];
            end
         end
         if (start_uart) begin
            checkOutput({tag, "_data"}, 32'(uart_tx_data), 32'(exp_q[0].data));
            checkOutput({tag, "_grant"}, 32'(grant), 32'(1 << exp_q[0].owner));
            if (!randomized)
               checkOutput({tag, "_rr_order"}, 32'(exp_q[0].owner), 32'(strobes % N));
            void'(exp_q.pop_front());
            strobes++;
         end
         cyc++;
      end
      checkOutput({tag, "_left_unsent"}, 32'(exp_q.size()), 0);
      applyStimulus('0, '0, '0, 1'b1);
      tick();
      tick();
      tick();
      checkOutput({tag, "_end_busy"}, 32'(busy), 0);
      checkOutput({tag, "_end_grant"}, 32'(grant), 0);
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      vecs[0]  = '{4'b0011, 0};
      vecs[1]  = '{4'b0011, 1};
      vecs[2]  = '{4'b0011, 0};
      vecs[3]  = '{4'b1000, 3};
      vecs[4]  = '{4'b1001, 0};
      vecs[5]  = '{4'b0100, 2};
      vecs[6]  = '{4'b0101, 0};
      vecs[7]  = '{4'b1111, 1};
      vecs[8]  = '{4'b1111, 2};
      vecs[9]  = '{4'b1111, 3};
      vecs[10] = '{4'b1111, 0};
      vecs[11] = '{4'b0010, 1};
      msg[0] = 8'h41;
      msg[1] = 8'h42;
      msg[2] = 8'h43;

      // Reset state, then a three-byte message from req0 at full rate
      doReset();
      checkResetValues("reset");
      b = 0;
      nstrobe = 0;
      last_c = 0;
      for (int c = 0; c < 14; c++) begin
         applyStimulus((b < 3) ? 4'b0001 : 4'b0000, {24'h0, msg[(b < 3) ? b : 2]},
                       {3'b000, b == 2}, 1'b1);
         hs = req_valid & req_ready;
         tick();
         if (hs[0]) b++;
         if (start_uart) begin
            checkOutput("seqA_data", 32'(uart_tx_data), 32'(msg[(nstrobe < 3) ? nstrobe : 0]));
            checkOutput("seqA_grant", 32'(grant), 1);
            if (nstrobe > 0) checkOutput("seqA_gap", 32'(c - last_c), 3);
            last_c = c;
            nstrobe++;
         end
      end
      checkOutput("seqA_count", 32'(nstrobe), 3);
      checkOutput("seqA_busy", 32'(busy), 0);
      checkOutput("seqA_grant_end", 32'(grant), 0);

      // Arbitration table of single-byte messages from a fresh reset
      doReset();
      for (int v = 0; v < 12; v++) begin
         applyStimulus(vecs[v].valid, tagData(4'(v)), '1, 1'b1);
         checkOutput("tbl_idle", 32'(busy), 0);
         tick();
         checkOutput("tbl_grant", 32'(grant), 32'(1 << vecs[v].exp_idx));
         checkOutput("tbl_ready", 32'(req_ready), 32'(1 << vecs[v].exp_idx));
         checkOutput("tbl_busy", 32'(busy), 1);
         tick();
         applyStimulus('0, '0, '0, 1'b1);
         checkOutput("tbl_strobe", 32'(start_uart), 1);
         checkOutput("tbl_data", 32'(uart_tx_data), 32'({4'(vecs[v].exp_idx), 4'(v)}));
         tick();
         checkOutput("tbl_no_double_strobe", 32'(start_uart), 0);
         tick();
         checkOutput("tbl_done_busy", 32'(busy), 0);
         checkOutput("tbl_done_grant", 32'(grant), 0);
      end

      // fifo_ready held low for 20 SEND cycles
      doReset();
      applyStimulus(4'b0010, 32'h0000_5A00, 4'b0010, 1'b0);
      tick();
      checkOutput("stall_grant", 32'(grant), 32'b0010);
      for (int c = 0; c < 20; c++) begin
         checkOutput("stall_ready", 32'(req_ready), 0);
         checkOutput("stall_start", 32'(start_uart), 0);
         tick();
      end
      applyStimulus(4'b0010, 32'h0000_5A00, 4'b0010, 1'b1);
      checkOutput("stall_release_ready", 32'(req_ready), 32'b0010);
      tick();
      checkOutput("stall_release_start", 32'(start_uart), 1);
      checkOutput("stall_release_data", 32'(uart_tx_data), 32'h5A);

      // All four requesters with single-byte messages: strict rotation
      doReset();
      runScenario(1'b0, "rr4");

      // Randomized traffic with valid gaps and fifo_ready stalls
      for (int r = 0; r < 4; r++) begin
         doReset();
         runScenario(1'b1, "rand");
      end

      // Reset in the first HOLD cycle of byte 2 of a 4-byte message
      doReset();
      b = 0;
      nstrobe = 0;
      for (int c = 0; c < 20 && nstrobe < 2; c++) begin
         applyStimulus(4'b0001, {24'h0, 8'hC0 + 8'(b)}, {3'b000, b == 3}, 1'b1);
         hs = req_valid & req_ready;
         tick();
         if (hs[0]) b++;
         if (start_uart) nstrobe++;
      end
      checkOutput("rsthold_reached", 32'(nstrobe), 2);
      checkOutput("rsthold_data_before", 32'(uart_tx_data), 32'hC1);
      rst = 1'b1;
      tick();
      checkResetValues("rsthold");
      rst = 1'b0;
      applyStimulus(4'b0101, tagData(4'hE), 4'b1111, 1'b1);
      tick();
      checkOutput("rsthold_next_grant", 32'(grant), 32'b0001);

      // req2 sends one non-last byte then goes silent while req3 waits
      doReset();
      applyStimulus(4'b1100, {8'h33, 8'h22, 16'h0000}, 4'b1000, 1'b1);
      tick();
      checkOutput("idle_owner_grant", 32'(grant), 32'b0100);
      checkOutput("idle_owner_ready", 32'(req_ready), 32'b0100);
      tick();
      applyStimulus(4'b1000, {8'h33, 8'h22, 16'h0000}, 4'b1000, 1'b1);
      checkOutput("idle_owner_strobe", 32'(start_uart), 1);
      checkOutput("idle_owner_data", 32'(uart_tx_data), 32'h22);
`ifdef UART_ARB_TIMEOUT_EN
      repeat (17) tick();
      checkOutput("to_before_timeout", 32'(timeout), 0);
      checkOutput("to_before_grant", 32'(grant), 32'b0100);
      tick();
      checkOutput("to_pulse", 32'(timeout), 1);
      checkOutput("to_grant_cleared", 32'(grant), 0);
      checkOutput("to_busy", 32'(busy), 0);
      tick();
      checkOutput("to_pulse_end", 32'(timeout), 0);
      checkOutput("to_next_grant", 32'(grant), 32'b1000);
`else
      repeat (40) tick();
      checkOutput("hold_forever_grant", 32'(grant), 32'b0100);
      checkOutput("hold_forever_busy", 32'(busy), 1);
      checkOutput("hold_forever_timeout", 32'(timeout), 0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single UART transmit FIFO block (start_uart / uart_tx_data / fifo_ready interface) between NUM_REQ byte-stream requesters.
- Grants whole messages atomically: once granted, a requester owns the UART until its byte flagged "last" is pushed.
- Grants rotate round-robin between messages.
- Paces pushes so the UART FIFO's registered, one-cycle-late fifo_ready flag can never cause a dropped byte.

Parameters:
- NUM_REQ, 4: number of requesters (2..8).
- TIMEOUT_CYCLES, 1024: idle cycles allowed in SEND before a grant is revoked. Used only with UART_ARB_TIMEOUT_EN.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- req_valid  input  NUM_REQ  per-requester byte valid
- req_data  input  8*NUM_REQ  per-requester byte; requester i occupies bits [8i+7:8i]
- req_last  input  NUM_REQ  byte is the final byte of its message
- req_ready  output  NUM_REQ  byte accepted this cycle when valid&&ready
- grant  output  NUM_REQ  one-hot current owner, all-zero when idle
- fifo_ready  input  1  UART FIFO can accept data (registered, lags by one cycle)
- start_uart  output  1  one-cycle enqueue strobe to UART FIFO
- uart_tx_data  output  8  byte presented with start_uart
- busy  output  1  high whenever state != IDLE
- timeout  output  1  one-cycle pulse when a grant is revoked (always 0 without the macro)

Behaviour:
- Reset values: grant=0, req_ready=0, start_uart=0, uart_tx_data=8'h00, busy=0, timeout=0, state=IDLE, rr_ptr=NUM_REQ-1, hold counter=0.
- Reset takes effect at the next clk edge from any state.
- A byte already strobed before reset stays in the UART FIFO. Any partially sent message is truncated; there is no resend.
- States: IDLE, SEND, HOLD.
- IDLE:
  - If any req_valid is high, select the first asserted index searching rr_ptr+1, rr_ptr+2, ... with modulo NUM_REQ wrap.
  - Register the one-hot grant and move to SEND.
  - Arbitration costs exactly one cycle.
  - Only req_valid participates; req_last is ignored here.
- SEND:
  - req_ready[g] = fifo_ready && (state==SEND). This is combinational from state and fifo_ready. All other req_ready bits are 0.
  - On req_valid[g]&&req_ready[g] (cycle t):
    - register start_uart=1 and uart_tx_data=req_data[g] for cycle t+1;
    - latch last_flag=req_last[g];
    - go to HOLD.
- HOLD:
  - Lasts exactly 2 cycles (t+1, t+2) so that fifo_ready reflects the new FIFO count by t+3.
  - start_uart is high only in the first HOLD cycle.
  - Exit is at end of t+2:
    - if last_flag: go to IDLE, rr_ptr <= g, grant <= 0;
    - otherwise: return to SEND, grant unchanged.
- Maximum throughput is 1 byte per 3 cycles.
- req_valid may drop and reassert mid-message; the grant is held. Other requesters wait regardless of their valid.
- fifo_ready=0 in SEND: stay in SEND with req_ready=0 and no strobe.
- A single-byte message (last on the first byte) is legal: IDLE→SEND→HOLD→IDLE.
- start_uart is never high on two consecutive cycles, and never high while grant==0.

Optional Feature:
- Macro UART_ARB_TIMEOUT_EN.
- When defined:
  - A 16-bit counter increments each SEND cycle without a transfer and clears on transfer or on leaving SEND.
  - When the counter reaches TIMEOUT_CYCLES-1: go to IDLE, rr_ptr <= g, grant <= 0, timeout pulses high for 1 cycle.
  - fifo_ready=0 cycles also count toward the timeout.
- When undefined:
  - No counter is built.
  - timeout is tied to 0.
  - A granted requester holds the UART indefinitely.

Test Plan:
- After reset, fifo_ready=1: req0 sends 8'h41, 8'h42, 8'h43 (last on 8'h43).
  - Expect start_uart strobes exactly 3 cycles apart with data 41, 42, 43.
  - Expect grant=0001 throughout, then 0000 and busy=0.
- req0 and req1 both valid at the first post-reset cycle, two-byte messages each.
  - Expect req0's message completes fully before grant=0010.
  - Expect no interleaving on uart_tx_data.
- All 4 requesters continuously sending single-byte messages.
  - Expect grant order 0,1,2,3,0,1, ...
  - Expect each index to get exactly 2 grants per 8 messages.
- fifo_ready held 0 for 20 cycles in SEND with req_valid high.
  - Expect req_ready=0 and no start_uart.
  - Expect the byte to be pushed 1 cycle after fifo_ready returns to 1.
- With UART_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16: req2 is granted, sends 1 non-last byte, then drops valid.
  - Expect timeout pulse after 16 SEND cycles and grant cleared.
  - Expect pending req3 granted next.
- rst asserted during HOLD of byte 2 of a 4-byte message.
  - Expect all outputs at reset values at the next edge.
  - Expect the next grant after release goes to req0 if valid.
